mem_access_ctrl: RTL and testbench

Bus-master side of the main-memory handshake. Accepts single read/write requests from the control unit, drives the memory address (A), write data (B), and RD/WR strobes, then waits for ACK. Captures read data and reports completion, or reports an error on timeout. Sits between the microcontroller/datapath and the main memory, which answers on the same A/B/RD/WR/ACK/Data bus.

---
 rtl/mem_access_ctrl_if.sv | 62 ++++++
 rtl/mem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Groups the two sides of the memory-access controller into one bundle:
//   the request/response side facing the control unit (Req, Write, Addr,
//   WrData, Busy, Done, Error, RdData) and the main-memory bus (A, B, RD, WR,
//   ACK, Data).
//   modport master : view of the controller itself (drives the memory bus
//                    and the status/response signals).
//   modport slave  : view of the surrounding logic (control unit + memory).
interface mem_access_ctrl_if #(
  parameter int DATAWIDTH_BUS = 32
);
  // Control-unit side
  logic                     MEM_ACCESS_CTRL_Req_In;
  logic                     MEM_ACCESS_CTRL_Write_In;
  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_Addr_InBus;
  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_WrData_InBus;
  logic                     MEM_ACCESS_CTRL_Busy_Out;
  logic                     MEM_ACCESS_CTRL_Done_Out;
  logic                     MEM_ACCESS_CTRL_Error_Out;
  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_RdData_OutBus;
  // Memory side
  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_MemA_OutBus;
  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_MemB_OutBus;
  logic                     MEM_ACCESS_CTRL_MemRD_Out;
  logic                     MEM_ACCESS_CTRL_MemWR_Out;
  logic                     MEM_ACCESS_CTRL_MemACK_In;
  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_MemData_InBus;

  modport master (
    input  MEM_ACCESS_CTRL_Req_In,
    input  MEM_ACCESS_CTRL_Write_In,
    input  MEM_ACCESS_CTRL_Addr_InBus,
    input  MEM_ACCESS_CTRL_WrData_InBus,
    output MEM_ACCESS_CTRL_Busy_Out,
    output MEM_ACCESS_CTRL_Done_Out,
    output MEM_ACCESS_CTRL_Error_Out,
    output MEM_ACCESS_CTRL_RdData_OutBus,
    output MEM_ACCESS_CTRL_MemA_OutBus,
    output MEM_ACCESS_CTRL_MemB_OutBus,
    output MEM_ACCESS_CTRL_MemRD_Out,
    output MEM_ACCESS_CTRL_MemWR_Out,
    input  MEM_ACCESS_CTRL_MemACK_In,
    input  MEM_ACCESS_CTRL_MemData_InBus
  );

  modport slave (
    output MEM_ACCESS_CTRL_Req_In,
    output MEM_ACCESS_CTRL_Write_In,
    output MEM_ACCESS_CTRL_Addr_InBus,
    output MEM_ACCESS_CTRL_WrData_InBus,
    input  MEM_ACCESS_CTRL_Busy_Out,
    input  MEM_ACCESS_CTRL_Done_Out,
    input  MEM_ACCESS_CTRL_Error_Out,
    input  MEM_ACCESS_CTRL_RdData_OutBus,
    input  MEM_ACCESS_CTRL_MemA_OutBus,
    input  MEM_ACCESS_CTRL_MemB_OutBus,
    input  MEM_ACCESS_CTRL_MemRD_Out,
    input  MEM_ACCESS_CTRL_MemWR_Out,
    output MEM_ACCESS_CTRL_MemACK_In,
    output MEM_ACCESS_CTRL_MemData_InBus
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Bus-master side of the main-memory handshake. A single read or write
//   request from the control unit is latched in IDLE, the address, write
//   data and RD/WR strobe are driven in ACCESS until ACK arrives or the
//   timeout expires, and RECOVER inserts one strobe-low cycle before the
//   next access.
// Ports:
//   MEM_ACCESS_CTRL_CLOCK_50        : clock, all state on the rising edge
//   MEM_ACCESS_CTRL_ResetInHigh_In  : synchronous active-high reset
//   bus (mem_access_ctrl_if.master) : control-unit request/response signals
//                                     and the memory A/B/RD/WR/ACK/Data bus
module mem_access_ctrl #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                 MEM_ACCESS_CTRL_CLOCK_50,
  input  logic                 MEM_ACCESS_CTRL_ResetInHigh_In,
  mem_access_ctrl_if.master    bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     write_q, write_d;
  logic                     rd_q, rd_d;
  logic                     wr_q, wr_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [DATAWIDTH_BUS-1:0] addr_q, addr_d;
  logic [DATAWIDTH_BUS-1:0] memb_q, memb_d;
  logic [DATAWIDTH_BUS-1:0] rdata_q, rdata_d;

  logic ack_seen;
  logic timed_out;

  assign ack_seen  = bus.MEM_ACCESS_CTRL_MemACK_In;
  assign timed_out = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge MEM_ACCESS_CTRL_CLOCK_50) begin
    if (MEM_ACCESS_CTRL_ResetInHigh_In) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      memb_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      memb_q  <= memb_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.MEM_ACCESS_CTRL_Req_In) state_d = S_ACCESS;
      S_ACCESS:  if (ack_seen || timed_out)      state_d = S_RECOVER;
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Registered-output next values. Done/Error are single-cycle pulses, so
  // they default low and are only raised on the ACCESS exit edge.
  always_comb begin
    cnt_d   = cnt_q;
    write_d = write_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    memb_d  = memb_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (bus.MEM_ACCESS_CTRL_Req_In) begin
          write_d = bus.MEM_ACCESS_CTRL_Write_In;
          addr_d  = bus.MEM_ACCESS_CTRL_Addr_InBus;
          // Reads park the write-data bus at zero.
          memb_d  = bus.MEM_ACCESS_CTRL_Write_In ? bus.MEM_ACCESS_CTRL_WrData_InBus : '0;
          rd_d    = ~bus.MEM_ACCESS_CTRL_Write_In;
          wr_d    = bus.MEM_ACCESS_CTRL_Write_In;
          cnt_d   = '0;
        end
      end
      S_ACCESS: begin
        if (ack_seen) begin
          if (!write_q) rdata_d = bus.MEM_ACCESS_CTRL_MemData_InBus;
          rd_d   = 1'b0;
          wr_d   = 1'b0;
          done_d = 1'b1;
        end else if (timed_out) begin
          rd_d  = 1'b0;
          wr_d  = 1'b0;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RECOVER: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
      default: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
    endcase
  end

  assign bus.MEM_ACCESS_CTRL_Busy_Out      = (state_q != S_IDLE);
  assign bus.MEM_ACCESS_CTRL_Done_Out      = done_q;
  assign bus.MEM_ACCESS_CTRL_Error_Out     = err_q;
  assign bus.MEM_ACCESS_CTRL_RdData_OutBus = rdata_q;
  assign bus.MEM_ACCESS_CTRL_MemA_OutBus   = addr_q;
  assign bus.MEM_ACCESS_CTRL_MemB_OutBus   = memb_q;
  assign bus.MEM_ACCESS_CTRL_MemRD_Out     = rd_q;
  assign bus.MEM_ACCESS_CTRL_MemWR_Out     = wr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam int W = 32;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  mem_access_ctrl_if #(.DATAWIDTH_BUS(W)) bus();

  mem_access_ctrl #(.DATAWIDTH_BUS(W), .TIMEOUT_CYCLES(T)) dut (
    .MEM_ACCESS_CTRL_CLOCK_50       (clk),
    .MEM_ACCESS_CTRL_ResetInHigh_In (rst),
    .bus                            (bus)
  );

  typedef struct {
    bit          is_err;
    int          fin_edge;
    logic [W-1:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  // Drives one request and watches it until Busy falls (bounded).
  // k: 0 = ACK tied high, -1 = ACK never, k>0 = ACK after k strobe cycles.
  task automatic run_access(input logic wr, input logic [W-1:0] addr,
                            input logic [W-1:0] wdata, input logic [W-1:0] mdata,
                            input int k,
                            output int n_strb, output int n_other, output int n_bad_ab,
                            output int done_edge, output int err_edge,
                            output int n_done, output int n_err, output int busy_cyc,
                            output logic [W-1:0] rd_end);
    logic own, other;
    n_strb = 0; n_other = 0; n_bad_ab = 0; done_edge = -1; err_edge = -1;
    n_done = 0; n_err = 0; busy_cyc = 0;
    @(negedge clk);
    bus.MEM_ACCESS_CTRL_Req_In        = 1'b1;
    bus.MEM_ACCESS_CTRL_Write_In      = wr;
    bus.MEM_ACCESS_CTRL_Addr_InBus    = addr;
    bus.MEM_ACCESS_CTRL_WrData_InBus  = wdata;
    bus.MEM_ACCESS_CTRL_MemData_InBus = mdata;
    bus.MEM_ACCESS_CTRL_MemACK_In     = (k == 0);
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) bus.MEM_ACCESS_CTRL_Req_In = 1'b0;
      if (!bus.MEM_ACCESS_CTRL_Busy_Out) break;
      busy_cyc++;
      own   = wr ? bus.MEM_ACCESS_CTRL_MemWR_Out : bus.MEM_ACCESS_CTRL_MemRD_Out;
      other = wr ? bus.MEM_ACCESS_CTRL_MemRD_Out : bus.MEM_ACCESS_CTRL_MemWR_Out;
      if (own) begin
        n_strb++;
        if (bus.MEM_ACCESS_CTRL_MemA_OutBus !== addr ||
            bus.MEM_ACCESS_CTRL_MemB_OutBus !== (wr ? wdata : '0)) n_bad_ab++;
      end
      if (other) n_other++;
      if (bus.MEM_ACCESS_CTRL_Done_Out)  begin n_done++; done_edge = c - 1; end
      if (bus.MEM_ACCESS_CTRL_Error_Out) begin n_err++;  err_edge  = c - 1; end
      if (k > 0) bus.MEM_ACCESS_CTRL_MemACK_In = own && (n_strb >= k);
    end
    rd_end = bus.MEM_ACCESS_CTRL_RdData_OutBus;
    if (k != 0) bus.MEM_ACCESS_CTRL_MemACK_In = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.MEM_ACCESS_CTRL_Req_In        = 1'b0;
    bus.MEM_ACCESS_CTRL_Write_In      = 1'b0;
    bus.MEM_ACCESS_CTRL_Addr_InBus    = '0;
    bus.MEM_ACCESS_CTRL_WrData_InBus  = '0;
    bus.MEM_ACCESS_CTRL_MemACK_In     = 1'b0;
    bus.MEM_ACCESS_CTRL_MemData_InBus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.MEM_ACCESS_CTRL_Busy_Out, bus.MEM_ACCESS_CTRL_Done_Out, bus.MEM_ACCESS_CTRL_Error_Out,
         bus.MEM_ACCESS_CTRL_MemRD_Out, bus.MEM_ACCESS_CTRL_MemWR_Out} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {bus.MEM_ACCESS_CTRL_Busy_Out,
               bus.MEM_ACCESS_CTRL_Done_Out, bus.MEM_ACCESS_CTRL_Error_Out,
               bus.MEM_ACCESS_CTRL_MemRD_Out, bus.MEM_ACCESS_CTRL_MemWR_Out});
    end
    checks++;
    if (bus.MEM_ACCESS_CTRL_RdData_OutBus !== '0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", bus.MEM_ACCESS_CTRL_RdData_OutBus);
    end
    checks++;
    if (bus.MEM_ACCESS_CTRL_MemA_OutBus !== '0) begin
      errors++; $display("FAIL reset_mema: got %h expected 0", bus.MEM_ACCESS_CTRL_MemA_OutBus);
    end
    checks++;
    if (bus.MEM_ACCESS_CTRL_MemB_OutBus !== '0) begin
      errors++; $display("FAIL reset_memb: got %h expected 0", bus.MEM_ACCESS_CTRL_MemB_OutBus);
    end
    rst = 1'b0;
  endtask

  // Shared result check against the scoreboard entry for one access.
  task automatic test_read_ack_tied();
    int ns, no, nb, de, ee, nd, ne, bc; logic [W-1:0] rde; exp_t e;
    exp_q.push_back('{is_err: 1'b0, fin_edge: 1, rdata: 32'h86804002});
    run_access(1'b0, 32'h2, 32'hCAFE0000, 32'h86804002, 0, ns, no, nb, de, ee, nd, ne, bc, rde);
    bus.MEM_ACCESS_CTRL_MemACK_In = 1'b0;
    e = exp_q.pop_front();
    checks++; if (de !== e.fin_edge) begin errors++; $display("FAIL rd_done_edge: got %0d expected %0d", de, e.fin_edge); end
    checks++; if (rde !== e.rdata) begin errors++; $display("FAIL rd_rdata: got %h expected %h", rde, e.rdata); end
    checks++; if (ns != 1) begin errors++; $display("FAIL rd_strobe_cycles: got %0d expected 1", ns); end
    checks++; if (nb != 0 || no != 0) begin errors++; $display("FAIL rd_bus: bad_ab %0d other %0d expected 0 0", nb, no); end
    checks++; if (bc != 2) begin errors++; $display("FAIL rd_busy_cycles: got %0d expected 2", bc); end
    checks++; if (nd != 1 || ne != 0) begin errors++; $display("FAIL rd_pulses: done %0d err %0d expected 1 0", nd, ne); end
  endtask

  task automatic test_write_delayed();
    int ns, no, nb, de, ee, nd, ne, bc; logic [W-1:0] rde; exp_t e;
    exp_q.push_back('{is_err: 1'b0, fin_edge: 3, rdata: 32'h86804002});
    run_access(1'b1, 32'h10, 32'hDEADBEEF, 32'h11111111, 3, ns, no, nb, de, ee, nd, ne, bc, rde);
    e = exp_q.pop_front();
    checks++; if (de !== e.fin_edge) begin errors++; $display("FAIL wr_done_edge: got %0d expected %0d", de, e.fin_edge); end
    checks++; if (rde !== e.rdata) begin errors++; $display("FAIL wr_rdata_kept: got %h expected %h", rde, e.rdata); end
    checks++; if (ns != 3) begin errors++; $display("FAIL wr_strobe_cycles: got %0d expected 3", ns); end
    checks++; if (nb != 0) begin errors++; $display("FAIL wr_ab_stable: bad cycles %0d expected 0", nb); end
    checks++; if (no != 0) begin errors++; $display("FAIL wr_rd_low: rd cycles %0d expected 0", no); end
    checks++; if (bc != 4) begin errors++; $display("FAIL wr_busy_cycles: got %0d expected 4", bc); end
  endtask

  task automatic test_timeout();
    int ns, no, nb, de, ee, nd, ne, bc; logic [W-1:0] rde; exp_t e;
    exp_q.push_back('{is_err: 1'b1, fin_edge: T, rdata: 32'h86804002});
    run_access(1'b0, 32'h44, 32'h0, 32'hFFFFFFFF, -1, ns, no, nb, de, ee, nd, ne, bc, rde);
    e = exp_q.pop_front();
    checks++; if (ee !== e.fin_edge) begin errors++; $display("FAIL to_err_edge: got %0d expected %0d", ee, e.fin_edge); end
    checks++; if (rde !== e.rdata) begin errors++; $display("FAIL to_rdata_kept: got %h expected %h", rde, e.rdata); end
    checks++; if (ns != T) begin errors++; $display("FAIL to_strobe_cycles: got %0d expected %0d", ns, T); end
    checks++; if (nd != 0 || ne != 1) begin errors++; $display("FAIL to_pulses: done %0d err %0d expected 0 1", nd, ne); end
    checks++; if (bc != T + 1) begin errors++; $display("FAIL to_busy_cycles: got %0d expected %0d", bc, T + 1); end
  endtask

  task automatic test_back_to_back();
    logic [12:0] strb_vec, exp_vec;
    int both; exp_t e;
    strb_vec = '0; exp_vec = 13'h0492; both = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{is_err: 1'b0, fin_edge: 1 + 3 * i, rdata: 32'h0BADF00D});
    @(negedge clk);
    bus.MEM_ACCESS_CTRL_Req_In        = 1'b1;
    bus.MEM_ACCESS_CTRL_Write_In      = 1'b0;
    bus.MEM_ACCESS_CTRL_Addr_InBus    = 32'h30;
    bus.MEM_ACCESS_CTRL_MemData_InBus = 32'h0BADF00D;
    bus.MEM_ACCESS_CTRL_MemACK_In     = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 12) bus.MEM_ACCESS_CTRL_Req_In = 1'b0;
      strb_vec[c] = bus.MEM_ACCESS_CTRL_MemRD_Out | bus.MEM_ACCESS_CTRL_MemWR_Out;
      if (bus.MEM_ACCESS_CTRL_MemRD_Out && bus.MEM_ACCESS_CTRL_MemWR_Out) both++;
      if (bus.MEM_ACCESS_CTRL_Done_Out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_done: got done at edge %0d expected none", c - 1);
        end else begin
          e = exp_q.pop_front();
          if (c - 1 != e.fin_edge || bus.MEM_ACCESS_CTRL_RdData_OutBus !== e.rdata) begin
            errors++;
            $display("FAIL b2b_done: got edge %0d data %h expected edge %0d data %h",
                     c - 1, bus.MEM_ACCESS_CTRL_RdData_OutBus, e.fin_edge, e.rdata);
          end
        end
      end
    end
    checks++; if (strb_vec !== exp_vec) begin errors++; $display("FAIL b2b_strobe_pattern: got %h expected %h", strb_vec, exp_vec); end
    checks++; if (both != 0) begin errors++; $display("FAIL b2b_rd_wr_both: got %0d expected 0", both); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing_done: got %0d left expected 0", exp_q.size()); end
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ack_idle();
    int strb, dn, bsy;
    strb = 0; dn = 0; bsy = 0;
    bus.MEM_ACCESS_CTRL_Req_In    = 1'b0;
    bus.MEM_ACCESS_CTRL_MemACK_In = 1'b1;
    bus.MEM_ACCESS_CTRL_MemData_InBus = 32'h77777777;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.MEM_ACCESS_CTRL_MemRD_Out || bus.MEM_ACCESS_CTRL_MemWR_Out) strb++;
      if (bus.MEM_ACCESS_CTRL_Done_Out || bus.MEM_ACCESS_CTRL_Error_Out) dn++;
      if (bus.MEM_ACCESS_CTRL_Busy_Out) bsy++;
    end
    checks++; if (strb != 0 || dn != 0 || bsy != 0) begin
      errors++; $display("FAIL idle_ack_activity: strobe %0d pulse %0d busy %0d expected 0 0 0", strb, dn, bsy);
    end
    checks++; if (bus.MEM_ACCESS_CTRL_RdData_OutBus !== 32'h0BADF00D || bus.MEM_ACCESS_CTRL_MemA_OutBus !== 32'h30) begin
      errors++; $display("FAIL idle_ack_hold: got rdata %h a %h expected 0badf00d 30",
                         bus.MEM_ACCESS_CTRL_RdData_OutBus, bus.MEM_ACCESS_CTRL_MemA_OutBus);
    end
    bus.MEM_ACCESS_CTRL_MemACK_In = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    bus.MEM_ACCESS_CTRL_Req_In     = 1'b1;
    bus.MEM_ACCESS_CTRL_Write_In   = 1'b0;
    bus.MEM_ACCESS_CTRL_Addr_InBus = 32'h55;
    bus.MEM_ACCESS_CTRL_MemACK_In  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.MEM_ACCESS_CTRL_Req_In = 1'b0;
    @(negedge clk);
    checks++; if (bus.MEM_ACCESS_CTRL_MemRD_Out !== 1'b1) begin
      errors++; $display("FAIL rst_pre_rd: got %b expected 1", bus.MEM_ACCESS_CTRL_MemRD_Out);
    end
    rst = 1'b1;
    bus.MEM_ACCESS_CTRL_Req_In = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.MEM_ACCESS_CTRL_MemRD_Out, bus.MEM_ACCESS_CTRL_Busy_Out, bus.MEM_ACCESS_CTRL_Done_Out,
         bus.MEM_ACCESS_CTRL_Error_Out} !== 4'b0) begin
      errors++; $display("FAIL rst_mid_ctrl: got %b expected 0000", {bus.MEM_ACCESS_CTRL_MemRD_Out,
               bus.MEM_ACCESS_CTRL_Busy_Out, bus.MEM_ACCESS_CTRL_Done_Out, bus.MEM_ACCESS_CTRL_Error_Out});
    end
    checks++;
    if (bus.MEM_ACCESS_CTRL_MemA_OutBus !== '0 || bus.MEM_ACCESS_CTRL_RdData_OutBus !== '0) begin
      errors++; $display("FAIL rst_mid_data: got a %h rdata %h expected 0 0",
                         bus.MEM_ACCESS_CTRL_MemA_OutBus, bus.MEM_ACCESS_CTRL_RdData_OutBus);
    end
    @(negedge clk);
    checks++;
    if (bus.MEM_ACCESS_CTRL_Busy_Out !== 1'b0 || bus.MEM_ACCESS_CTRL_MemRD_Out !== 1'b0) begin
      errors++; $display("FAIL rst_req_ignored: got busy %b rd %b expected 0 0",
                         bus.MEM_ACCESS_CTRL_Busy_Out, bus.MEM_ACCESS_CTRL_MemRD_Out);
    end
    rst = 1'b0;
    bus.MEM_ACCESS_CTRL_Req_In = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_ack_tied();
    test_write_delayed();
    test_timeout();
    test_back_to_back();
    test_ack_idle();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
